// File: rtl/button_conditioner.sv
// N-channel synchronizer + debouncer with press/release pulses and optional auto-repeat.
// Latency SYNC_STAGES+DB_CYCLES edges from din to level/pulse; no handshake, sample every cycle.
module button_conditioner #(
  parameter int N             = 2,
  parameter int SYNC_STAGES   = 2,
  parameter int DB_CYCLES     = 16,
  parameter int REPEAT_DELAY  = 0,
  parameter int REPEAT_PERIOD = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic [N-1:0] din,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse
);

  localparam int CW   = $clog2(DB_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = $clog2(RMAX + 1);
  localparam bit REPEAT_EN = (REPEAT_DELAY != 0);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  logic [N-1:0]  sync_q  [SYNC_STAGES];
  logic [N-1:0]  sync_d  [SYNC_STAGES];
  logic [N-1:0]  s;
  logic [N-1:0]  level_q, level_d;
  logic [N-1:0]  press_q, press_d;
  logic [N-1:0]  release_q, release_d;
  logic [CW-1:0] cnt_q   [N];
  logic [CW-1:0] cnt_d   [N];
  logic [RW-1:0] rc_q    [N];
  logic [RW-1:0] rc_d    [N];
  logic [1:0]    state_q [N];
  logic [1:0]    state_d [N];

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d[0] = din;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    for (int ch = 0; ch < N; ch++) begin
      cnt_d[ch]   = cnt_q[ch];
      rc_d[ch]    = rc_q[ch];
      state_d[ch] = state_q[ch];

      if (s[ch] == level_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CW'(DB_CYCLES - 1)) begin
        level_d[ch] = s[ch];
        cnt_d[ch]   = '0;
        if (s[ch]) press_d[ch]   = 1'b1;
        else       release_d[ch] = 1'b1;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CW'(1);
      end

      // An accepted fall always wins over a repeat pulse in the same cycle.
      if (REPEAT_EN) begin
        case (state_q[ch])
          ST_IDLE: begin
            if (press_d[ch]) begin
              state_d[ch] = ST_DELAY;
              rc_d[ch]    = '0;
            end
          end
          ST_DELAY: begin
            if (release_d[ch]) begin
              state_d[ch] = ST_IDLE;
              rc_d[ch]    = '0;
            end else if (rc_q[ch] == RW'(REPEAT_DELAY - 1)) begin
              press_d[ch] = 1'b1;
              rc_d[ch]    = '0;
              state_d[ch] = ST_REPEAT;
            end else begin
              rc_d[ch] = rc_q[ch] + RW'(1);
            end
          end
          ST_REPEAT: begin
            if (release_d[ch]) begin
              state_d[ch] = ST_IDLE;
              rc_d[ch]    = '0;
            end else if (rc_q[ch] == RW'(REPEAT_PERIOD - 1)) begin
              press_d[ch] = 1'b1;
              rc_d[ch]    = '0;
            end else begin
              rc_d[ch] = rc_q[ch] + RW'(1);
            end
          end
          default: begin
            state_d[ch] = ST_IDLE;
            rc_d[ch]    = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
      for (int ch = 0; ch < N; ch++) begin
        cnt_q[ch]   <= '0;
        rc_q[ch]    <= '0;
        state_q[ch] <= ST_IDLE;
      end
    end else begin
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      for (int ch = 0; ch < N; ch++) begin
        cnt_q[ch]   <= cnt_d[ch];
        rc_q[ch]    <= rc_d[ch];
        state_q[ch] <= state_d[ch];
      end
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: vector table, directed corner sequences, and a
// randomized run against an edge-history reference model.
module tb_button_conditioner;

  localparam int N    = 2;
  localparam int SYNC = 2;
  localparam int DB   = 4;
  localparam int RD   = 10;
  localparam int RP   = 5;

  logic         Clk = 1'b0;
  logic         Reset;
  logic [N-1:0] din;
  logic [N-1:0] level, press, release_pulse;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: raw input history since reset, judged by the debounce rule.
  logic [N-1:0] hist[$];
  int           k_m;
  logic [N-1:0] level_m, press_m, rel_m;
  int           p_m [N];

  typedef struct {
    logic [N-1:0] d;
    logic         rst;
    logic [N-1:0] lvl;
    logic [N-1:0] prs;
    logic [N-1:0] rel;
  } vec_t;
  vec_t tbl[$];

  button_conditioner #(
    .N(N), .SYNC_STAGES(SYNC), .DB_CYCLES(DB),
    .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
  ) dut (
    .Clk(Clk), .Reset(Reset), .din(din),
    .level(level), .press(press), .release_pulse(release_pulse)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Synchronizer output seen by the debouncer at edge j (1-based since reset).
  function automatic logic samp(input int j, input int ch);
    logic [N-1:0] v;
    if (j <= SYNC) return 1'b0;
    v = hist[j-SYNC-1];
    return v[ch];
  endfunction

  task automatic model_step(input logic [N-1:0] d, input logic r);
    press_m = '0;
    rel_m   = '0;
    if (r) begin
      hist.delete();
      k_m     = 0;
      level_m = '0;
      return;
    end
    k_m++;
    hist.push_back(d);
    for (int ch = 0; ch < N; ch++) begin
      logic flip;
      int   dt;
      flip = (k_m >= DB);
      for (int j = k_m - DB + 1; j <= k_m; j++)
        if (j >= 1 && samp(j, ch) == level_m[ch]) flip = 1'b0;
      if (flip) begin
        if (!level_m[ch]) begin
          level_m[ch] = 1'b1;
          press_m[ch] = 1'b1;
          p_m[ch]     = k_m;
        end else begin
          level_m[ch] = 1'b0;
          rel_m[ch]   = 1'b1;
        end
      end else if (level_m[ch] && RD > 0) begin
        dt = k_m - p_m[ch];
        if (dt == RD || (dt > RD && (dt - RD) % RP == 0)) press_m[ch] = 1'b1;
      end
    end
  endtask

  task automatic tick(input logic [N-1:0] d, input logic r);
    din   = d;
    Reset = r;
    @(posedge Clk);
    model_step(d, r);
    @(negedge Clk);
    chk($sformatf("model_level k=%0d", k_m), 32'(level), 32'(level_m));
    chk($sformatf("model_press k=%0d", k_m), 32'(press), 32'(press_m));
    chk($sformatf("model_release k=%0d", k_m), 32'(release_pulse), 32'(rel_m));
    chk($sformatf("pulse_exclusive k=%0d", k_m), 32'(press & release_pulse), 32'd0);
  endtask

  task automatic add(input logic [N-1:0] d, input logic r, input logic [N-1:0] l,
                     input logic [N-1:0] p, input logic [N-1:0] rl);
    vec_t v;
    v.d = d; v.rst = r; v.lvl = l; v.prs = p; v.rel = rl;
    tbl.push_back(v);
  endtask

  initial begin
    int pc, pk, relc, first_p;
    int pq[$];
    int rq[$];
    int exp_p [4];
    logic [N-1:0] any_v, cur;
    logic r;

    din   = '0;
    Reset = 1'b1;
    for (int ch = 0; ch < N; ch++) p_m[ch] = 0;
    level_m = '0; press_m = '0; rel_m = '0; k_m = 0;

    // Clean press on channel 0, then clean fall: rise at edge 6, fall at edge 14.
    add(2'b00, 1'b1, 2'b00, 2'b00, 2'b00);
    for (int i = 1; i <= 5; i++) add(2'b01, 1'b0, 2'b00, 2'b00, 2'b00);
    add(2'b01, 1'b0, 2'b01, 2'b01, 2'b00);
    for (int i = 7; i <= 8; i++) add(2'b01, 1'b0, 2'b01, 2'b00, 2'b00);
    for (int i = 9; i <= 13; i++) add(2'b00, 1'b0, 2'b01, 2'b00, 2'b00);
    add(2'b00, 1'b0, 2'b00, 2'b00, 2'b01);

    for (int i = 0; i < tbl.size(); i++) begin
      tick(tbl[i].d, tbl[i].rst);
      chk($sformatf("tbl%0d_level", i), 32'(level), 32'(tbl[i].lvl));
      chk($sformatf("tbl%0d_press", i), 32'(press), 32'(tbl[i].prs));
      chk($sformatf("tbl%0d_release", i), 32'(release_pulse), 32'(tbl[i].rel));
    end

    // Bounce: 3-cycle runs never qualify; settle after edge 12 gives press at 18.
    tick(2'b00, 1'b1);
    pc = 0; pk = -1; relc = 0;
    for (int k = 1; k <= 22; k++) begin
      logic b;
      b = (k <= 3) ? 1'b1 : (k <= 6) ? 1'b0 : (k <= 9) ? 1'b1 : (k <= 12) ? 1'b0 : 1'b1;
      tick({1'b0, b}, 1'b0);
      if (press[0]) begin pc++; pk = k_m; end
      if (release_pulse[0]) relc++;
    end
    chk("bounce_press_count", pc, 1);
    chk("bounce_press_edge", pk, 18);
    chk("bounce_release_count", relc, 0);

    // Auto-repeat on channel 1: P=6, presses 6,16,21,26; din drops after edge 23.
    tick(2'b00, 1'b1);
    exp_p[0] = 6; exp_p[1] = 16; exp_p[2] = 21; exp_p[3] = 26;
    for (int k = 1; k <= 34; k++) begin
      tick({(k <= 23) ? 1'b1 : 1'b0, 1'b0}, 1'b0);
      if (press[1]) pq.push_back(k_m);
      if (release_pulse[1]) rq.push_back(k_m);
    end
    chk("repeat_press_count", pq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk($sformatf("repeat_press%0d_edge", i), (i < pq.size()) ? pq[i] : -1, exp_p[i]);
    chk("repeat_release_count", rq.size(), 1);
    chk("repeat_release_edge", (rq.size() > 0) ? rq[0] : -1, 29);
    chk("repeat_level_after", 32'(level[1]), 32'd0);

    // Simultaneous rise and fall on both channels.
    tick(2'b00, 1'b1);
    for (int k = 1; k <= 16; k++) begin
      tick((k <= 8) ? 2'b11 : 2'b00, 1'b0);
      if (k == 6)  chk("simul_press", 32'(press), 32'h3);
      if (k == 14) chk("simul_release", 32'(release_pulse), 32'h3);
    end

    // Reset while channel 0 is in the repeat phase with din still high.
    tick(2'b00, 1'b1);
    for (int k = 1; k <= 23; k++) tick(2'b01, 1'b0);
    tick(2'b01, 1'b1);
    chk("midreset_level", 32'(level), 32'd0);
    chk("midreset_press", 32'(press), 32'd0);
    chk("midreset_release", 32'(release_pulse), 32'd0);
    first_p = -1;
    for (int k = 1; k <= 8; k++) begin
      tick(2'b01, 1'b0);
      if (press[0] && first_p < 0) first_p = k;
    end
    chk("midreset_fresh_press_edge", first_p, 6);

    // Short glitch: 3-cycle high pulse must leave everything quiet.
    tick(2'b00, 1'b1);
    any_v = '0;
    for (int k = 1; k <= 14; k++) begin
      tick((k <= 3) ? 2'b01 : 2'b00, 1'b0);
      any_v = any_v | level | press | release_pulse;
    end
    chk("glitch_quiet", 32'(any_v), 32'd0);

    // Randomized run: mostly-held levels with occasional toggles and resets.
    tick(2'b00, 1'b1);
    cur = '0;
    for (int i = 0; i < 3000; i++) begin
      for (int ch = 0; ch < N; ch++)
        if ($urandom_range(0, 5) == 0) cur[ch] = ~cur[ch];
      r = ($urandom_range(0, 399) == 0);
      tick(cur, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
